alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Issue and writeback stage directly upstream of the 4-bit combinational ALU. It accepts commands over a valid/ready handshake and holds a small operand register file. It drives the ALU's A, B and op inputs from registered operands, then writes the ALU result back to the register file. It also reports each completed result with a zero flag.

## Interface
Parameters:
- DATA_W, 4, operand/result width; must match the ALU's A/B/alu_out width
- REG_N, 4, register file depth; register addresses are 2 bits wide

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  stage can accept a command this cycle
- cmd_load  in  1  1 = write cmd_imm to cmd_dst, no ALU use; 0 = ALU command
- cmd_op  in  3  ALU opcode: 000 zero, 001 add, 010 sub, 011 and, 100 or, 101 not A, 110 not B, 111 zero
- cmd_src_a  in  2  register index for operand A
- cmd_src_b  in  2  register index for operand B
- cmd_dst  in  2  destination register index
- cmd_imm  in  DATA_W  immediate value for loads
- alu_a  out  DATA_W  registered operand to ALU input A
- alu_b  out  DATA_W  registered operand to ALU input B
- alu_op  out  3  registered opcode to ALU input op
- alu_result  in  DATA_W  combinational ALU output, sampled in the same cycle it is driven
- res_valid  out  1  one-cycle pulse: a register write completed
- res_data  out  DATA_W  value written
- res_dst  out  2  register written
- res_zero  out  1  res_data == 0
- busy  out  1  high in EXEC

## Operation
The block has two FSM states, IDLE and EXEC.

- **Acceptance:** a command is accepted when `cmd_valid & cmd_ready`.
- **cmd_ready:** equals (state == IDLE) & ~rst.
- **Load in IDLE:**
  - On accept, write regfile[cmd_dst] = cmd_imm at that edge.
  - Drive res_data = cmd_imm, res_dst = cmd_dst and res_valid = 1 for the next cycle.
  - Remain in IDLE.
- **ALU command in IDLE:**
  - On accept, register alu_a = regfile[cmd_src_a], alu_b = regfile[cmd_src_b] and alu_op = cmd_op.
  - Latch cmd_dst internally and go to EXEC.
- **EXEC (exactly one cycle):** cmd_ready = 0 and busy = 1. At the end-of-EXEC edge:
  - write regfile[dst] = alu_result;
  - set res_data = alu_result, res_dst = dst, res_valid = 1 for the next cycle;
  - set alu_op = 000;
  - return to IDLE.
- **Operand drive outside EXEC:** alu_op is 000 whenever not in EXEC. alu_a and alu_b hold their last values.
- **Register file reads:** the register file is read at accept using current contents. No forwarding is needed, because every write completes at or before the edge where the next command is accepted.
- **Aliasing:** src_a == src_b is legal. dst equal to either source is legal; the old value is used as the operand.
- **Arithmetic:** all arithmetic is modulo 2^DATA_W, as produced by the ALU. The block never widens or sign-extends.
- **res_zero:** derived from the registered res_data; meaningful only while res_valid = 1.
- **res_valid:** deasserts on the cycle after its pulse unless a new completion occurs at that edge.

## Timing
- **Reset values:** when rst is high at an edge:
  - state = IDLE;
  - all register file entries = 0;
  - alu_a = 0, alu_b = 0, alu_op = 000;
  - res_valid = 0, res_data = 0, res_dst = 0, res_zero = 0 (res_zero reads 0 during reset);
  - busy = 0;
  - cmd_ready = 0 while rst is high.
- **Load latency:** command accepted at edge N → res_valid during cycle N+1. Throughput is 1 load/cycle.
- **ALU latency:** command accepted at edge N → EXEC during cycle N+1 → res_valid during cycle N+2. Throughput is 1 ALU command per 2 cycles.
- **Back-to-back commands:** a command can be accepted in the same cycle res_valid is high.
- **Stall:** cmd_valid held through EXEC is not accepted. The command fields must stay stable until accepted.
- **Reset during EXEC:** the command is aborted. No writeback, no res_valid pulse, and the block is in IDLE on the cycle after reset.
- **Reset coincident with an accept edge:** the command is dropped and its register write does not occur.

## Test plan
- Reset, then load r0=9, r1=8 on consecutive cycles, then ADD (001) r2=r0+r1 → res_valid on the 2 load cycles and 2 cycles after the ALU accept; res_data=1, res_dst=2, res_zero=0.
- Load r3=5, then SUB (010) r0=r3-r3 → res_data=0, res_zero=1, r0 reads back as 0 via a subsequent OR (100) r0|r0 → 0.
- NOT A (101) with r0=9 → res_data=6; NOT B (110) with r1=0 → res_data=15; opcode 111 → res_data=0.
- cmd_valid held continuously with two ALU commands → cmd_ready low during EXEC, second accepted exactly 2 cycles after the first, busy high one cycle each.
- Assert rst during EXEC of ADD r2 → no res_valid, r2 unchanged (0), alu_op=000, cmd_ready returns 1 the cycle after rst drops.
- Four back-to-back loads r0..r3 = 1,2,3,4 → four consecutive res_valid pulses with matching res_dst/res_data; AND (011) r3&r2 → res_data=0, res_zero=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback stage in front of a combinational ALU: accepts load and ALU
// commands, keeps a small register file, drives registered ALU operands and
// writes the ALU result back one cycle later.
module alu_issue_ctrl #(
    parameter int DATA_W = 4,
    parameter int REG_N  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_load,
    input  logic [2:0]        cmd_op,
    input  logic [1:0]        cmd_src_a,
    input  logic [1:0]        cmd_src_b,
    input  logic [1:0]        cmd_dst,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [1:0]        res_dst,
    output logic              res_zero,
    output logic              busy
);

    typedef enum logic {
        IDLE,
        EXEC
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs [REG_N];
    logic [1:0]        dst_q;

    logic              accept;
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;

    assign cmd_ready = (state_q == IDLE) & ~rst;
    assign busy      = (state_q == EXEC);
    assign accept    = cmd_valid & cmd_ready;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_addr = cmd_dst;
        wr_data = cmd_imm;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_load) begin
                        wr_en = 1'b1;
                    end else begin
                        state_d = EXEC;
                    end
                end
            end
            EXEC: begin
                // The ALU result is sampled in the same cycle it is driven.
                wr_en   = 1'b1;
                wr_addr = dst_q;
                wr_data = alu_result;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, which is what makes accept-time reads of the
    // register file see the contents before this edge's write.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dst_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 3'b000;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_dst   <= '0;
            res_zero  <= 1'b0;
            // NOTE: the register file is small and must read 0 after reset,
            // so it is cleared here rather than left as an unreset RAM.
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            res_valid <= wr_en;
            if (wr_en) begin
                regs[wr_addr] <= wr_data;
                res_data      <= wr_data;
                res_dst       <= wr_addr;
                res_zero      <= (wr_data == '0);
            end
            if (accept && !cmd_load) begin
                alu_a  <= regs[cmd_src_a];
                alu_b  <= regs[cmd_src_b];
                alu_op <= cmd_op;
                dst_q  <= cmd_dst;
            end else if (state_q == EXEC) begin
                alu_op <= 3'b000;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 4-bit ALU attached to
// the operand outputs; expected values are hand-computed per scenario.
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_load;
    logic [2:0] cmd_op;
    logic [1:0] cmd_src_a;
    logic [1:0] cmd_src_b;
    logic [1:0] cmd_dst;
    logic [3:0] cmd_imm;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_op;
    logic [3:0] alu_result;
    logic       res_valid;
    logic [3:0] res_data;
    logic [1:0] res_dst;
    logic       res_zero;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    // {res_valid, res_dst, res_data, res_zero}
    wire [7:0]  res_vec  = {res_valid, res_dst, res_data, res_zero};
    // {cmd_ready, busy, alu_op}
    wire [4:0]  ctl_vec  = {cmd_ready, busy, alu_op};
    // {alu_a, alu_b, alu_op}
    wire [10:0] opnd_vec = {alu_a, alu_b, alu_op};

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 4'd0;
        case (alu_op)
            3'b001:  alu_result = alu_a + alu_b;
            3'b010:  alu_result = alu_a - alu_b;
            3'b011:  alu_result = alu_a & alu_b;
            3'b100:  alu_result = alu_a | alu_b;
            3'b101:  alu_result = ~alu_a;
            3'b110:  alu_result = ~alu_b;
            default: alu_result = 4'd0;
        endcase
    end

    alu_issue_ctrl #(.DATA_W(4), .REG_N(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_load   (cmd_load),
        .cmd_op     (cmd_op),
        .cmd_src_a  (cmd_src_a),
        .cmd_src_b  (cmd_src_b),
        .cmd_dst    (cmd_dst),
        .cmd_imm    (cmd_imm),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_dst    (res_dst),
        .res_zero   (res_zero),
        .busy       (busy)
    );

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic set_load(input logic [1:0] d, input logic [3:0] v);
        cmd_valid = 1'b1;
        cmd_load  = 1'b1;
        cmd_dst   = d;
        cmd_imm   = v;
    endtask

    task automatic set_alu(input logic [2:0] op, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] d);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = op;
        cmd_src_a = a;
        cmd_src_b = b;
        cmd_dst   = d;
    endtask

    task automatic clear_cmd();
        cmd_valid = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_cmd();
        step();
        step();
        n_cmp++;
        if (res_vec !== 8'b0) begin
            n_err++;
            $display("FAIL reset_res: got %b want %b", res_vec, 8'b0);
        end
        n_cmp++;
        if (ctl_vec !== 5'b0) begin
            n_err++;
            $display("FAIL reset_ctl: got %b want %b", ctl_vec, 5'b0);
        end
        n_cmp++;
        if (opnd_vec !== 11'b0) begin
            n_err++;
            $display("FAIL reset_opnd: got %b want %b", opnd_vec, 11'b0);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (ctl_vec !== 5'b10_000) begin
            n_err++;
            $display("FAIL reset_release_ready: got %b want %b", ctl_vec, 5'b10_000);
        end
    endtask

    task automatic test_load_add();
        set_load(2'd0, 4'd9);
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd0, 4'd9, 1'b0}) begin
            n_err++;
            $display("FAIL load_r0: got %b want %b", res_vec, {1'b1, 2'd0, 4'd9, 1'b0});
        end
        set_load(2'd1, 4'd8);
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd1, 4'd8, 1'b0}) begin
            n_err++;
            $display("FAIL load_r1: got %b want %b", res_vec, {1'b1, 2'd1, 4'd8, 1'b0});
        end
        set_alu(3'b001, 2'd0, 2'd1, 2'd2);
        step();
        n_cmp++;
        if ({ctl_vec, res_valid} !== {5'b01_001, 1'b0}) begin
            n_err++;
            $display("FAIL add_exec_ctl: got %b want %b", {ctl_vec, res_valid}, {5'b01_001, 1'b0});
        end
        n_cmp++;
        if (opnd_vec !== {4'd9, 4'd8, 3'b001}) begin
            n_err++;
            $display("FAIL add_exec_opnd: got %b want %b", opnd_vec, {4'd9, 4'd8, 3'b001});
        end
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd2, 4'd1, 1'b0}) begin
            n_err++;
            $display("FAIL add_result: got %b want %b", res_vec, {1'b1, 2'd2, 4'd1, 1'b0});
        end
        n_cmp++;
        if (ctl_vec !== 5'b10_000) begin
            n_err++;
            $display("FAIL add_back_idle: got %b want %b", ctl_vec, 5'b10_000);
        end
        step();
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL add_pulse_end: got %b want 0", res_valid);
        end
    endtask

    task automatic test_sub_zero();
        set_load(2'd3, 4'd5);
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd3, 4'd5, 1'b0}) begin
            n_err++;
            $display("FAIL load_r3: got %b want %b", res_vec, {1'b1, 2'd3, 4'd5, 1'b0});
        end
        set_alu(3'b010, 2'd3, 2'd3, 2'd0);
        step();
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL sub_self_zero: got %b want %b", res_vec, {1'b1, 2'd0, 4'd0, 1'b1});
        end
        set_alu(3'b100, 2'd0, 2'd0, 2'd0);
        step();
        n_cmp++;
        if (opnd_vec !== {4'd0, 4'd0, 3'b100}) begin
            n_err++;
            $display("FAIL or_readback_opnd: got %b want %b", opnd_vec, {4'd0, 4'd0, 3'b100});
        end
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL or_readback: got %b want %b", res_vec, {1'b1, 2'd0, 4'd0, 1'b1});
        end
    endtask

    task automatic test_not_ops();
        set_load(2'd0, 4'd9);
        step();
        set_load(2'd1, 4'd0);
        step();
        set_alu(3'b101, 2'd0, 2'd1, 2'd2);
        step();
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd2, 4'd6, 1'b0}) begin
            n_err++;
            $display("FAIL not_a: got %b want %b", res_vec, {1'b1, 2'd2, 4'd6, 1'b0});
        end
        set_alu(3'b110, 2'd0, 2'd1, 2'd3);
        step();
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd3, 4'd15, 1'b0}) begin
            n_err++;
            $display("FAIL not_b: got %b want %b", res_vec, {1'b1, 2'd3, 4'd15, 1'b0});
        end
        set_alu(3'b111, 2'd0, 2'd1, 2'd2);
        step();
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd2, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL op_111_zero: got %b want %b", res_vec, {1'b1, 2'd2, 4'd0, 1'b1});
        end
    endtask

    // r0=9, r3=15 here: ADD wraps to 8, then SUB r0-r1 reads the new r1.
    task automatic test_stall();
        set_alu(3'b001, 2'd0, 2'd3, 2'd1);
        step();
        n_cmp++;
        if (ctl_vec !== 5'b01_001) begin
            n_err++;
            $display("FAIL stall_exec1_ctl: got %b want %b", ctl_vec, 5'b01_001);
        end
        n_cmp++;
        if (opnd_vec !== {4'd9, 4'd15, 3'b001}) begin
            n_err++;
            $display("FAIL stall_exec1_opnd: got %b want %b", opnd_vec, {4'd9, 4'd15, 3'b001});
        end
        set_alu(3'b010, 2'd0, 2'd1, 2'd2);
        step();
        n_cmp++;
        if ({ctl_vec, res_vec} !== {5'b10_000, 1'b1, 2'd1, 4'd8, 1'b0}) begin
            n_err++;
            $display("FAIL stall_gap: got %b want %b", {ctl_vec, res_vec},
                     {5'b10_000, 1'b1, 2'd1, 4'd8, 1'b0});
        end
        step();
        n_cmp++;
        if ({ctl_vec, alu_a, alu_b} !== {5'b01_010, 4'd9, 4'd8}) begin
            n_err++;
            $display("FAIL stall_exec2: got %b want %b", {ctl_vec, alu_a, alu_b},
                     {5'b01_010, 4'd9, 4'd8});
        end
        clear_cmd();
        step();
        n_cmp++;
        if ({busy, res_vec} !== {1'b0, 1'b1, 2'd2, 4'd1, 1'b0}) begin
            n_err++;
            $display("FAIL stall_result2: got %b want %b", {busy, res_vec},
                     {1'b0, 1'b1, 2'd2, 4'd1, 1'b0});
        end
    endtask

    task automatic test_reset_exec();
        set_alu(3'b001, 2'd0, 2'd1, 2'd2);
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rexec_busy: got %b want 1", busy);
        end
        rst = 1'b1;
        clear_cmd();
        step();
        n_cmp++;
        if ({ctl_vec, res_vec} !== 13'b0) begin
            n_err++;
            $display("FAIL rexec_in_reset: got %b want %b", {ctl_vec, res_vec}, 13'b0);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if ({ctl_vec, res_valid} !== {5'b10_000, 1'b0}) begin
            n_err++;
            $display("FAIL rexec_after: got %b want %b", {ctl_vec, res_valid}, {5'b10_000, 1'b0});
        end
        set_alu(3'b100, 2'd2, 2'd2, 2'd2);
        step();
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd2, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rexec_r2_zero: got %b want %b", res_vec, {1'b1, 2'd2, 4'd0, 1'b1});
        end
        // A load presented while rst is high must be dropped.
        rst = 1'b1;
        set_load(2'd1, 4'd7);
        step();
        rst = 1'b0;
        clear_cmd();
        step();
        n_cmp++;
        if (res_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rst_load_pulse: got %b want 0", res_valid);
        end
        set_alu(3'b100, 2'd1, 2'd1, 2'd1);
        step();
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd1, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL rst_load_dropped: got %b want %b", res_vec, {1'b1, 2'd1, 4'd0, 1'b1});
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 4'(i + 1);
            set_load(2'(i), v);
            step();
            n_cmp++;
            if (res_vec !== {1'b1, 2'(i), v, 1'b0}) begin
                n_err++;
                $display("FAIL b2b_load%0d: got %b want %b", i, res_vec, {1'b1, 2'(i), v, 1'b0});
            end
        end
        set_alu(3'b011, 2'd3, 2'd2, 2'd0);
        step();
        n_cmp++;
        if (opnd_vec !== {4'd4, 4'd3, 3'b011}) begin
            n_err++;
            $display("FAIL b2b_and_opnd: got %b want %b", opnd_vec, {4'd4, 4'd3, 3'b011});
        end
        clear_cmd();
        step();
        n_cmp++;
        if (res_vec !== {1'b1, 2'd0, 4'd0, 1'b1}) begin
            n_err++;
            $display("FAIL b2b_and: got %b want %b", res_vec, {1'b1, 2'd0, 4'd0, 1'b1});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = 3'b000;
        cmd_src_a = 2'd0;
        cmd_src_b = 2'd0;
        cmd_dst   = 2'd0;
        cmd_imm   = 4'd0;
        test_reset();
        test_load_add();
        test_sub_zero();
        test_not_ops();
        test_stall();
        test_reset_exec();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
